// File: rtl/deagg_src_arbiter.sv
// rtl/deagg_src_arbiter.sv - round-robin burst arbiter sharing one deaggregator among wide-word sources
//
// Purpose: grants one source FIFO at a time to the deaggregator sender port for a
// burst of up to burst_len wide words, then rotates priority past the last winner.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   burst_len       wide words per grant, latched at grant time (0 behaves as 1)
//   src_data        packed source words, source s in slice s
//   src_empty_n     per-source "holds a word" flags
//   src_deq         per-source pop strobes (one-hot or zero)
//   dagg_data       granted source word to the deaggregator
//   dagg_empty_n    granted source non-empty flag to the deaggregator
//   dagg_deq        deaggregator pop request
//   grant_valid     a source is currently granted
//   grant_id        index of the granted source
module deagg_src_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_SENDERS = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int BURST_WIDTH = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [BURST_WIDTH-1:0]                     burst_len,
  input  logic [NUM_SENDERS*FETCH_WIDTH*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SENDERS-1:0]                     src_empty_n,
  output logic [NUM_SENDERS-1:0]                     src_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0]          dagg_data,
  output logic                                       dagg_empty_n,
  input  logic                                       dagg_deq,
  output logic                                       grant_valid,
  output logic [SEL_WIDTH-1:0]                       grant_id
);

  localparam int WW = FETCH_WIDTH * DATA_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0]   last_id;
  logic [BURST_WIDTH-1:0] beat_cnt;
  logic [BURST_WIDTH-1:0] blen;

  logic                 req_any;
  logic                 found;
  logic [SEL_WIDTH-1:0] winner;
  logic                 cur_empty_n;
  logic                 deq_fire;

  // Round-robin pick: first pass takes requesters above last_id, second pass
  // wraps around to requesters at or below it (last_id itself comes last).
  always_comb begin
    req_any = |src_empty_n;
    found   = 1'b0;
    winner  = '0;
    for (int s = 0; s < NUM_SENDERS; s++) begin
      if (!found && src_empty_n[s] && (SEL_WIDTH'(s) > last_id)) begin
        found  = 1'b1;
        winner = SEL_WIDTH'(s);
      end
    end
    for (int s = 0; s < NUM_SENDERS; s++) begin
      if (!found && src_empty_n[s] && (SEL_WIDTH'(s) <= last_id)) begin
        found  = 1'b1;
        winner = SEL_WIDTH'(s);
      end
    end
  end

  // Steer the granted source to the deaggregator; everything is zero outside GRANT
  // so a deq request with nothing granted can never reach a source.
  always_comb begin
    dagg_data   = '0;
    cur_empty_n = 1'b0;
    src_deq     = '0;
    if (state == GRANT) begin
      for (int s = 0; s < NUM_SENDERS; s++) begin
        if (grant_id == SEL_WIDTH'(s)) begin
          dagg_data   = src_data[s*WW +: WW];
          cur_empty_n = src_empty_n[s];
          src_deq[s]  = dagg_deq & src_empty_n[s];
        end
      end
    end
  end

  assign dagg_empty_n = cur_empty_n;
  assign deq_fire     = dagg_deq & cur_empty_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_id     <= SEL_WIDTH'(NUM_SENDERS - 1);
      beat_cnt    <= '0;
      blen        <= BURST_WIDTH'(1);
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_id    <= winner;
            beat_cnt    <= '0;
            blen        <= (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;
          end
        end
        GRANT: begin
          if (!cur_empty_n) begin
            // Granted source ran dry: give the slot up early.
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_id     <= grant_id;
          end else if (deq_fire) begin
            if ((beat_cnt + BURST_WIDTH'(1)) == blen) begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              last_id     <= grant_id;
            end else begin
              beat_cnt <= beat_cnt + BURST_WIDTH'(1);
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
